// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC control unit.
//   - 5-bit opcode constants and IR field positions
//   - sequencer state encoding (T0..T7 are consecutive so execute steps can increment)
//   - instruction classes produced by the opcode decoder
//   - last_state(): final execute step of each class
package minisrc_pkg;

    // IR field positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int C_MSB  = 18;
    localparam int C_LSB  = 0;

    // Opcodes
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        S_STOP  = 4'd9,
        S_HALT  = 4'd10
    } state_e;

    typedef enum logic [4:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU3, CLS_ALUI, CLS_ALU2, CLS_MULDIV,
        CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO,
        CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } class_e;

    function automatic logic [4:0] ir_op(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    // Final execute state of each class; NOP/ILLEGAL never leave fetch.
    function automatic state_e last_state(input class_e c);
        case (c)
            CLS_LD, CLS_ST:                 return T7;
            CLS_MULDIV, CLS_BR:             return T6;
            CLS_LDI, CLS_ALU3, CLS_ALUI:    return T5;
            CLS_ALU2, CLS_JAL:              return T4;
            default:                        return T3;
        endcase
    endfunction

endpackage

// File: rtl/minisrc_opcode_decode.sv
// Combinational opcode decoder.
//   op  : 5-bit opcode
//   cls : instruction class selecting the execute sequence
//   alu : ALU operation code used in the class's Z_in step
module minisrc_opcode_decode
    import minisrc_pkg::*;
(
    input  logic [4:0] op,
    output class_e     cls,
    output logic [4:0] alu
);

    always_comb begin
        cls = CLS_ILLEGAL;
        alu = OP_ADD;
        case (op)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL: begin
                cls = CLS_ALU3;
                alu = op;
            end
            OP_ADDI: cls = CLS_ALUI;
            OP_ANDI: begin
                cls = CLS_ALUI;
                alu = OP_AND;
            end
            OP_ORI: begin
                cls = CLS_ALUI;
                alu = OP_OR;
            end
            OP_MUL, OP_DIV: begin
                cls = CLS_MULDIV;
                alu = op;
            end
            OP_NEG, OP_NOT: begin
                cls = CLS_ALU2;
                alu = op;
            end
            OP_BR:   cls = CLS_BR;
            OP_JR:   cls = CLS_JR;
            OP_JAL:  cls = CLS_JAL;
            OP_IN:   cls = CLS_IN;
            OP_OUT:  cls = CLS_OUT;
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired control sequencer for the Mini SRC datapath.
//   clk, clr (async active-low)      : clock and reset
//   IR_Data                          : instruction register contents
//   CON_out                          : branch condition, gates PC_in in br T6
//   stop                             : pause request, taken at instruction boundary
//   *_in / IncPC / CON_in            : register load enables
//   *_out / C_out / BAout / Rout     : bus drive enables
//   Read, Write                      : memory strobes
//   Gra, Grb, Grc, Rin               : register select/encode
//   alu_instruction_bits             : ALU operation
//   link_rx_in                       : one-hot link register load for jal
//   run                              : high in T0..T7
//   illegal_op                       : one-clock pulse after fetching an undefined opcode
module minisrc_control_unit
    import minisrc_pkg::*;
#(
    parameter int LINK_REG = 15,
    parameter int NREG     = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     IR_Data,
    input  logic            CON_out,
    input  logic            stop,
    output logic            PC_in, IR_in, Y_in, Z_in, HI_in, LO_in,
    output logic            MAR_in, MDR_in, OutPort_in, IncPC, CON_in,
    output logic            PC_out, Zhigh_out, Zlow_out, HI_out, LO_out,
    output logic            MDR_out, InPort_out, C_out,
    output logic            Read, Write,
    output logic            Gra, Grb, Grc, Rin, Rout, BAout,
    output logic [4:0]      alu_instruction_bits,
    output logic [NREG-1:0] link_rx_in,
    output logic            run,
    output logic            illegal_op
);

    state_e     state_reg, state_next;
    logic [4:0] op_reg;
    logic       illegal_reg;
    logic [4:0] dec_op;
    class_e     cls;
    logic [4:0] dec_alu;
    state_e     boundary;
    logic       unused_ir;

    // Only the opcode field steers sequencing; register fields go straight to the datapath.
    assign unused_ir = ^IR_Data[RA_MSB:C_LSB];

    // In T2 the new instruction is decoded live so nop/undefined can skip execute;
    // afterwards the latched opcode is used.
    assign dec_op = (state_reg == T2) ? ir_op(IR_Data) : op_reg;

    minisrc_opcode_decode u_decode (
        .op  (dec_op),
        .cls (cls),
        .alu (dec_alu)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= S_RESET;
            op_reg      <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= (state_reg == T2) && (cls == CLS_ILLEGAL);
            if (state_reg == T2)
                op_reg <= ir_op(IR_Data);
        end
    end

    assign illegal_op = illegal_reg;
    assign boundary   = stop ? S_STOP : T0;

    always_comb begin
        state_next = state_reg;
        {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in} = '0;
        {PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out} = '0;
        {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        alu_instruction_bits = '0;
        link_rx_in           = '0;
        run                  = (state_reg >= T0) && (state_reg <= T7);

        case (state_reg)
            S_RESET: state_next = T0;
            T0: begin
                PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
                state_next = T1;
            end
            T1: begin
                Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
                state_next = T2;
            end
            T2: begin
                MDR_out = 1'b1; IR_in = 1'b1;
                if (cls == CLS_NOP || cls == CLS_ILLEGAL)
                    state_next = boundary;
                else
                    state_next = T3;
            end
            S_STOP:  state_next = stop ? S_STOP : T0;
            S_HALT:  state_next = S_HALT;
            default: begin
                if (state_reg >= last_state(cls))
                    state_next = (cls == CLS_HALT) ? S_HALT : boundary;
                else
                    state_next = state_e'(state_reg + 4'd1);
            end
        endcase

        if (state_reg >= T3 && state_reg <= T7) begin
            case (cls)
                CLS_LD, CLS_LDI, CLS_ST: begin
                    case (state_reg)
                        T3: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
                        T4: begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = dec_alu; end
                        T5: begin
                            Zlow_out = 1'b1;
                            if (cls == CLS_LDI) begin
                                Gra = 1'b1; Rin = 1'b1;
                            end else begin
                                MAR_in = 1'b1;
                            end
                        end
                        T6: begin
                            MDR_in = 1'b1;
                            if (cls == CLS_ST) begin
                                Gra = 1'b1; Rout = 1'b1;
                            end else begin
                                Read = 1'b1;
                            end
                        end
                        T7: begin
                            if (cls == CLS_ST) begin
                                Write = 1'b1;
                            end else begin
                                MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                CLS_ALU3, CLS_ALUI: begin
                    case (state_reg)
                        T3: begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                        T4: begin
                            Z_in = 1'b1; alu_instruction_bits = dec_alu;
                            if (cls == CLS_ALU3) begin
                                Grc = 1'b1; Rout = 1'b1;
                            end else begin
                                C_out = 1'b1;
                            end
                        end
                        T5: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
                CLS_ALU2: begin
                    if (state_reg == T3) begin
                        Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = dec_alu;
                    end else if (state_reg == T4) begin
                        Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                end
                CLS_MULDIV: begin
                    case (state_reg)
                        T3: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                        T4: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = dec_alu; end
                        T5: begin Zlow_out = 1'b1; LO_in = 1'b1; end
                        T6: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
                        default: ;
                    endcase
                end
                CLS_BR: begin
                    case (state_reg)
                        T3: begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
                        T4: begin PC_out = 1'b1; Y_in = 1'b1; end
                        T5: begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = dec_alu; end
                        // Target is always computed; the CON flip-flop decides whether PC takes it.
                        T6: begin Zlow_out = 1'b1; PC_in = CON_out; end
                        default: ;
                    endcase
                end
                CLS_JR: begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
                CLS_JAL: begin
                    // Return address (already-incremented PC) goes to the link register first.
                    if (state_reg == T3) begin
                        PC_out = 1'b1; link_rx_in = NREG'(1) << LINK_REG;
                    end else begin
                        Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1;
                    end
                end
                CLS_IN:   begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
                CLS_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minisrc_control_unit.sv
module tb_minisrc_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR_Data;
    logic        CON_out;
    logic        stop;
    logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in;
    logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_instruction_bits;
    logic [15:0] link_rx_in;
    logic        run, illegal_op;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    minisrc_control_unit #(.LINK_REG(15), .NREG(16)) dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .stop(stop),
        .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
        .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC), .CON_in(CON_in),
        .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
        .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .alu_instruction_bits(alu_instruction_bits), .link_rx_in(link_rx_in),
        .run(run), .illegal_op(illegal_op)
    );

    logic [26:0] ctrl;
    assign ctrl = {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
                   CON_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out,
                   C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

    localparam logic [26:0] M_PC_IN = 27'd1 << 26, M_IR_IN = 27'd1 << 25, M_Y_IN = 27'd1 << 24,
        M_Z_IN = 27'd1 << 23, M_HI_IN = 27'd1 << 22, M_LO_IN = 27'd1 << 21, M_MAR_IN = 27'd1 << 20,
        M_MDR_IN = 27'd1 << 19, M_OUTP_IN = 27'd1 << 18, M_INCPC = 27'd1 << 17,
        M_CON_IN = 27'd1 << 16, M_PC_OUT = 27'd1 << 15, M_ZHI_OUT = 27'd1 << 14,
        M_ZLO_OUT = 27'd1 << 13, M_HI_OUT = 27'd1 << 12, M_LO_OUT = 27'd1 << 11,
        M_MDR_OUT = 27'd1 << 10, M_INP_OUT = 27'd1 << 9, M_C_OUT = 27'd1 << 8,
        M_READ = 27'd1 << 7, M_WRITE = 27'd1 << 6, M_GRA = 27'd1 << 5, M_GRB = 27'd1 << 4,
        M_GRC = 27'd1 << 3, M_RIN = 27'd1 << 2, M_ROUT = 27'd1 << 1, M_BAOUT = 27'd1;

    localparam logic [26:0] F_T0 = M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN;
    localparam logic [26:0] F_T1 = M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN;
    localparam logic [26:0] F_T2 = M_MDR_OUT | M_IR_IN;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0; IR_Data = 'x; CON_out = 1'bx; stop = 1'bx;
        tick(); tick();
        tests++;
        if (ctrl !== 27'd0 || alu_instruction_bits !== 5'd0 || link_rx_in !== 16'd0 ||
            run !== 1'b0 || illegal_op !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ctrl=%h alu=%h link=%h run=%b ill=%b, required all 0",
                     ctrl, alu_instruction_bits, link_rx_in, run, illegal_op);
        end
        clr = 1'b1; IR_Data = 32'h0; CON_out = 1'b0; stop = 1'b0;
        tick();
        tests++;
        if (ctrl !== F_T0 || run !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_t0: ctrl=%h run=%b, required ctrl=%h run=1", ctrl, run, F_T0);
        end
        tick(); tick(); tick(); // ld of IR=0 runs T1..T3; finish it before continuing
        for (int i = 0; i < 4; i++) tick();
    endtask

    // add R1,R2,R3: T0..T5 then T0
    task automatic test_add();
        logic [26:0] e [0:6];
        logic [4:0]  a [0:6];
        e = '{F_T0, F_T1, F_T2, M_GRB|M_ROUT|M_Y_IN, M_GRC|M_ROUT|M_Z_IN, M_ZLO_OUT|M_GRA|M_RIN, F_T0};
        a = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
        IR_Data = 32'h18918000;
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (ctrl !== e[i] || alu_instruction_bits !== a[i] || run !== 1'b1) begin
                fails++;
                $display("FAIL add_cycle%0d: ctrl=%h alu=%h run=%b, required ctrl=%h alu=%h run=1",
                         i, ctrl, alu_instruction_bits, run, e[i], a[i]);
            end
            if (i < 6) tick();
        end
    endtask

    // brmi R6,25 with CON_out = 1 then 0
    task automatic test_branch();
        logic [26:0] e [0:7];
        for (int c = 1; c >= 0; c--) begin
            e = '{F_T0, F_T1, F_T2, M_GRA|M_ROUT|M_CON_IN, M_PC_OUT|M_Y_IN, M_C_OUT|M_Z_IN,
                  (c == 1) ? (M_ZLO_OUT|M_PC_IN) : M_ZLO_OUT, F_T0};
            IR_Data = 32'h9B180019;
            CON_out = c[0];
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (ctrl !== e[i] || (i == 5 && alu_instruction_bits !== 5'd3)) begin
                    fails++;
                    $display("FAIL br_con%0d_cycle%0d: ctrl=%h alu=%h, required ctrl=%h",
                             c, i, ctrl, alu_instruction_bits, e[i]);
                end
                if (i < 7) tick();
            end
        end
        CON_out = 1'b0;
    endtask

    // ld R1,0x55(R2): 8 cycles
    task automatic test_load();
        logic [26:0] e [0:8];
        e = '{F_T0, F_T1, F_T2, M_GRB|M_BAOUT|M_Y_IN, M_C_OUT|M_Z_IN, M_ZLO_OUT|M_MAR_IN,
              M_READ|M_MDR_IN, M_MDR_OUT|M_GRA|M_RIN, F_T0};
        IR_Data = 32'h00900055;
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (ctrl !== e[i] || (i == 4 && alu_instruction_bits !== 5'd3)) begin
                fails++;
                $display("FAIL ld_cycle%0d: ctrl=%h alu=%h, required ctrl=%h", i, ctrl,
                         alu_instruction_bits, e[i]);
            end
            if (i < 8) tick();
        end
    endtask

    // undefined opcode 11111 then nop: both skip execute; illegal_op pulses once
    task automatic test_illegal_nop();
        logic [26:0] e [0:6];
        logic        p [0:6];
        e = '{F_T0, F_T1, F_T2, F_T0, F_T1, F_T2, F_T0};
        p = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        IR_Data = 32'hF8000000;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) IR_Data = 32'hD0000000;
            tests++;
            if (ctrl !== e[i] || illegal_op !== p[i]) begin
                fails++;
                $display("FAIL illegal_nop_cycle%0d: ctrl=%h ill=%b, required ctrl=%h ill=%b",
                         i, ctrl, illegal_op, e[i], p[i]);
            end
            if (i < 6) tick();
        end
    endtask

    // jal: link one-hot in T3, jump in T4
    task automatic test_jal();
        logic [26:0] e [0:5];
        logic [15:0] l [0:5];
        e = '{F_T0, F_T1, F_T2, M_PC_OUT, M_GRA|M_ROUT|M_PC_IN, F_T0};
        l = '{16'h0, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0};
        IR_Data = 32'hA8800000;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (ctrl !== e[i] || link_rx_in !== l[i]) begin
                fails++;
                $display("FAIL jal_cycle%0d: ctrl=%h link=%h, required ctrl=%h link=%h",
                         i, ctrl, link_rx_in, e[i], l[i]);
            end
            if (i < 5) tick();
        end
    endtask

    // stop raised during add: add completes, then S_STOP until stop drops
    task automatic test_stop();
        IR_Data = 32'h18918000;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) stop = 1'b1;
            tests++;
            if (run !== 1'b1) begin
                fails++;
                $display("FAIL stop_add_cycle%0d: run=%b, required 1", i, run);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (run !== 1'b0 || ctrl !== 27'd0) begin
                fails++;
                $display("FAIL stop_hold%0d: run=%b ctrl=%h, required run=0 ctrl=0", i, run, ctrl);
            end
            tick();
        end
        stop = 1'b0;
        tick();
        tests++;
        if (run !== 1'b1 || ctrl !== F_T0) begin
            fails++;
            $display("FAIL stop_resume: run=%b ctrl=%h, required run=1 ctrl=%h", run, ctrl, F_T0);
        end
    endtask

    // st sequence, then reset during the Write step kills it immediately
    task automatic test_store_reset();
        logic [26:0] e [0:7];
        e = '{F_T0, F_T1, F_T2, M_GRB|M_BAOUT|M_Y_IN, M_C_OUT|M_Z_IN, M_ZLO_OUT|M_MAR_IN,
              M_GRA|M_ROUT|M_MDR_IN, M_WRITE};
        IR_Data = 32'h10800000;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (ctrl !== e[i]) begin
                fails++;
                $display("FAIL st_cycle%0d: ctrl=%h, required %h", i, ctrl, e[i]);
            end
            if (i < 7) tick();
        end
        clr = 1'b0;
        #1;
        tests++;
        if (Write !== 1'b0 || run !== 1'b0) begin
            fails++;
            $display("FAIL st_async_reset: Write=%b run=%b, required 0 0", Write, run);
        end
        @(negedge clk);
        clr = 1'b1;
        tick();
        tests++;
        if (ctrl !== F_T0) begin
            fails++;
            $display("FAIL st_reset_t0: ctrl=%h, required %h", ctrl, F_T0);
        end
    endtask

    task automatic test_halt();
        int waited;
        IR_Data = 32'hD8000000;
        tick(); tick();
        waited = 0;
        while (run === 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        tests++;
        if (run !== 1'b0) begin
            fails++;
            $display("FAIL halt_enter: run=%b after %0d cycles, required 0", run, waited);
        end
        stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) stop = 1'b0;
            tests++;
            if (run !== 1'b0 || ctrl !== 27'd0) begin
                fails++;
                $display("FAIL halt_hold%0d: run=%b ctrl=%h, required run=0 ctrl=0", i, run, ctrl);
            end
            tick();
        end
        clr = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        tests++;
        if (run !== 1'b1 || ctrl !== F_T0) begin
            fails++;
            $display("FAIL halt_reset_t0: run=%b ctrl=%h, required run=1 ctrl=%h", run, ctrl, F_T0);
        end
    endtask

    initial begin
        test_reset();
        // Re-align on a fresh T0 regardless of where the reset instruction ended.
        clr = 1'b0; tick(); clr = 1'b1; IR_Data = 32'h0; tick();
        test_add();
        test_branch();
        test_load();
        test_illegal_nop();
        test_jal();
        test_stop();
        test_store_reset();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/minisrc_control_unit.md
Name: minisrc_control_unit

Overview:
- Hardwired control sequencer for the Mini SRC CPU; sits directly upstream of `datapath` and drives every control input the datapath exposes.
- Runs instruction fetch (T0–T2), decodes the opcode from `IR_Data`, then steps through the per-class execute states.
- The datapath's `CON_out` gates PC load for conditional branches.
- Replaces the hand-timed `Present_state` sequences used in testbenches.

Parameters:
- `LINK_REG`, 15: register index written with the return address by `jal`.
- `NREG`, 16: register count; sets the width of `link_rx_in`.

Ports:
- `clk` in 1: system clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `IR_Data` in 32: current instruction register contents.
- `CON_out` in 1: branch condition from the CON FF.
- `stop` in 1: pause request, honoured only at instruction boundary.
- `PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in` out 1 each: register load enables.
- `PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out` out 1 each: bus drive enables.
- `Read, Write` out 1: memory strobes.
- `Gra, Grb, Grc, Rin, Rout, BAout` out 1: select/encode controls.
- `alu_instruction_bits` out 5: ALU operation code.
- `link_rx_in` out NREG: one-hot register load for the `jal` link.
- `run` out 1: high while executing.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.

Behaviour:
- **State and output timing.**
  - One state per clock.
  - State register plus opcode latch (captured on T2→T3 edge from `IR_Data[31:27]`).
  - Outputs are a combinational decode of registered state; the only exception is `PC_in` in `br` T6 (see below).
  - Any output not listed for a state is 0.
- **Reset.**
  - `clr` low forces state `S_RESET` asynchronously.
  - In `S_RESET` all outputs are 0, `run`=0 and the opcode latch is cleared.
  - The first rising edge after `clr` rises moves to T0.
  - Reset mid-instruction abandons it immediately; no partial `Write` completes.
- **Fetch.**
  - T0: `PC_out`, `MAR_in`, `IncPC`, `Z_in`.
  - T1: `Zlow_out`, `PC_in`, `Read`, `MDR_in`.
  - T2: `MDR_out`, `IR_in`.
- **Execute (T3 onward).**
  - `ld`: T3 `Grb BAout Y_in`; T4 `C_out`, alu=ADD, `Z_in`; T5 `Zlow_out MAR_in`; T6 `Read MDR_in`; T7 `MDR_out Gra Rin`.
  - `ldi`: T3–T4 as `ld`; T5 `Zlow_out Gra Rin`.
  - `st`: T3–T5 as `ld`; T6 `Gra Rout MDR_in` (`Read`=0); T7 `Write`.
  - R-type ALU (`add, sub, and, or, shr, shra, shl, ror, rol`): T3 `Grb Rout Y_in`; T4 `Grc Rout`, alu=opcode, `Z_in`; T5 `Zlow_out Gra Rin`.
  - `addi/andi/ori`: T3 `Grb Rout Y_in`; T4 `C_out`, alu=ADD/AND/OR, `Z_in`; T5 `Zlow_out Gra Rin`.
  - `neg/not`: T3 `Grb Rout`, alu=opcode, `Z_in`; T4 `Zlow_out Gra Rin`.
  - `mul/div`: T3 `Gra Rout Y_in`; T4 `Grb Rout`, alu=opcode, `Z_in`; T5 `Zlow_out LO_in`; T6 `Zhigh_out HI_in`.
  - `br`: T3 `Gra Rout CON_in`; T4 `PC_out Y_in`; T5 `C_out`, alu=ADD, `Z_in`; T6 `Zlow_out`, with `PC_in` = `CON_out`.
  - `jr`: T3 `Gra Rout PC_in`.
  - `jal`: T3 `PC_out`, `link_rx_in`=one-hot(`LINK_REG`); T4 `Gra Rout PC_in`.
  - `in`: T3 `InPort_out Gra Rin`.
  - `out`: T3 `Gra Rout OutPort_in`.
  - `mfhi`: T3 `HI_out Gra Rin`. `mflo`: T3 `LO_out Gra Rin`.
  - `nop`: no T3; T2 goes directly to T0.
  - Undefined opcode: behaves as `nop`; `illegal_op`=1 during T2→T0 cycle (registered pulse, one clock).
- **Instruction boundaries.**
  - After an instruction's last execute state the next state is T0, unless `stop`=1 sampled on that edge, which goes to `S_STOP`.
  - `S_STOP`: all outputs 0, `run`=0; stays while `stop`=1; goes to T0 on the first edge with `stop`=0.
  - `halt`: T3 enters `S_HALT`; all outputs 0, `run`=0; exits only via reset; `stop` is ignored.
  - `run`=1 in all T-states.

Decomposition:
- `minisrc_pkg`:
  - 5-bit opcode constants (`ld`=00000 … `add`=00011 … `br`=10011 … `halt`=11011).
  - State enum: `S_RESET`, T0–T7, `S_STOP`, `S_HALT`.
  - IR field positions: op[31:27], ra[26:23], rb[22:19], rc[18:15], C[18:0].
- Sub-module `minisrc_opcode_decode`: combinational opcode → instruction class plus ALU code; instanced once.

Test Plan:
- Reset with `clr`=0, all inputs X → every output 0, `run`=0; release `clr` → T0 control set on the next cycle.
- `IR_Data`=0x18918000 (add R1,R2,R3) → 6-cycle instruction:
  - T4: `Grc`, `Rout`, alu=00011, `Z_in`.
  - T5: `Zlow_out`, `Gra`, `Rin`.
  - Next cycle T0.
- `IR_Data`=0x9B180019 (brmi R6,25):
  - `CON_out`=1 → `PC_in`=1 in T6 (7th cycle).
  - Repeat with `CON_out`=0 → `PC_in`=0 in T6, `Zlow_out`=1.
- `IR_Data`=0x00900055 (ld R1,0x55(R2)) → T3 `BAout`+`Y_in`, T6 `Read`+`MDR_in`, T7 `MDR_out`+`Rin`; 8 cycles total.
- `stop`=1 asserted mid-add:
  - Instruction completes.
  - `S_STOP` with `run`=0.
  - `stop`=0 → T0 next edge.
- `IR_Data`=0xD8000000 (halt) → `S_HALT`, `run`=0, held 20 cycles; `clr` pulse → T0.
